// File: rtl/rom_burst_reader.sv
// Burst read initiator for a single-port registered ROM: issues one read per word,
// presents each word on a valid/ready stream and accumulates an additive checksum.
module rom_burst_reader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              enable,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] outdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);
    // state   | meaning
    // IDLE    | waiting for start
    // ISSUE   | ROM read strobe for cur_addr
    // WAIT    | ROM read latency; word captured at end of cycle
    // PRESENT | word offered to consumer until accepted
    // DONE    | one-cycle done pulse, checksum final
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        PRESENT = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] addr_r;
    logic [LEN_W-1:0]  remaining;
    logic [DATA_W-1:0] data_r;
    logic [DATA_W-1:0] sum_r;
    logic              last;

    assign last = (remaining == LEN_W'(1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = (length != '0) ? ISSUE : DONE;
            end
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = PRESENT;
            PRESENT: begin
                if (out_ready) state_nxt = last ? DONE : ISSUE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        enable    = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            ISSUE:   enable    = 1'b1;
            PRESENT: out_valid = 1'b1;
            DONE:    done      = 1'b1;
            default: ;
        endcase
    end

    // addr_r only moves when a new read is about to be issued, so addr holds
    // its last driven value while enable is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr  <= '0;
            addr_r    <= '0;
            remaining <= '0;
            data_r    <= '0;
            sum_r     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_addr  <= base_addr;
                        remaining <= length;
                        sum_r     <= '0;
                        if (length != '0) addr_r <= base_addr;
                    end
                end
                WAIT: data_r <= outdata;
                PRESENT: begin
                    if (out_ready) begin
                        sum_r     <= sum_r + data_r;
                        remaining <= remaining - 1'b1;
                        cur_addr  <= cur_addr + 1'b1;
                        if (!last) addr_r <= cur_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign addr     = addr_r;
    assign out_data = data_r;
    assign checksum = sum_r;

endmodule
